// File: rtl/rng_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rng_arb_pkg
// Description : Shared definitions for the round-robin burst arbiter.
//               Holds the FSM state encodings, source count, burst counter
//               width and the round-robin winner helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rng_arb_pkg;

  localparam int NUM_SRC = 4;
  localparam int BCNT_W  = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // Round-robin pick: the scan order is last+1, last+2, last+3, last.
  // The loop runs from the lowest to the highest priority, so the
  // highest-priority set bit is the last one written.
  function automatic logic [1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                         input logic [1:0]         last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/rng_mux_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module      : mux
// Description : Combinational 4:1 data selector.
// Ports       : in_1..in_4 - source data (sources 0..3)
//               sel        - source index
//               out_data   - selected data
// Revision    : 1.0 - initial release
// ============================================================================
module mux #(
  parameter int WIDTH_4 = 4,
  parameter int WIDTH_2 = 2
) (
  input  logic [WIDTH_4-1:0] in_1,
  input  logic [WIDTH_4-1:0] in_2,
  input  logic [WIDTH_4-1:0] in_3,
  input  logic [WIDTH_4-1:0] in_4,
  input  logic [WIDTH_2-1:0] sel,
  output logic [WIDTH_4-1:0] out_data
);

  always_comb begin
    out_data = in_1;
    case (sel[1:0])
      2'd0:    out_data = in_1;
      2'd1:    out_data = in_2;
      2'd2:    out_data = in_3;
      default: out_data = in_4;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rng_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rng_mux_arbiter
// Description : Four-source round-robin arbiter with burst grants feeding a
//               4:1 data mux. Each grant carries burst_len+1 beats, ends
//               early if the granted source drops its request, and is always
//               followed by a one-cycle gap before the next arbitration.
// Ports       : clk, rst_n       - clock, async active-low reset
//               req[3:0]         - per-source requests
//               in_1..in_4       - source data
//               burst_len[3:0]   - beats per grant minus one (sampled at grant)
//               out_ready        - downstream accepts a beat
//               out_valid        - beat present on out_data
//               out_data         - data of the granted source
//               gnt[3:0]         - one-hot grant
//               sel              - index of the granted source
// Revision    : 1.0 - initial release
// ============================================================================
module rng_mux_arbiter
  import rng_arb_pkg::*;
#(
  parameter int WIDTH_4 = 4,
  parameter int WIDTH_2 = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [WIDTH_4-1:0] in_1,
  input  logic [WIDTH_4-1:0] in_2,
  input  logic [WIDTH_4-1:0] in_3,
  input  logic [WIDTH_4-1:0] in_4,
  input  logic [3:0]         burst_len,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH_4-1:0] out_data,
  output logic [3:0]         gnt,
  output logic [WIDTH_2-1:0] sel
);

  logic [1:0]        state;
  logic [1:0]        last_src;
  logic [BCNT_W-1:0] burst_q;
  logic [BCNT_W-1:0] beat_cnt;
  logic [1:0]        pick;
  logic              req_sel;

  assign req_sel   = req[sel[1:0]];
  assign pick      = rr_pick(req, last_src);
  // Valid follows the live request of the granted source, so a dropped
  // request suppresses the beat in the same cycle.
  assign out_valid = (state == SERVE) && req_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      last_src <= 2'd3;
      burst_q  <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        SERVE: begin
          if (!req_sel) begin
            state <= GAP;
            gnt   <= '0;
          end else if (out_ready) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (beat_cnt == burst_q) begin
              state <= GAP;
              gnt   <= '0;
            end
          end
        end
        // IDLE and GAP arbitrate identically; GAP differs only in that it
        // is always entered for exactly one cycle after a grant.
        default: begin
          if (|req) begin
            state    <= SERVE;
            sel      <= WIDTH_2'(pick);
            gnt      <= 4'b0001 << pick;
            last_src <= pick;
            burst_q  <= burst_len;
            beat_cnt <= '0;
          end else begin
            state <= IDLE;
            gnt   <= '0;
          end
        end
      endcase
    end
  end

  mux #(
    .WIDTH_4 (WIDTH_4),
    .WIDTH_2 (WIDTH_2)
  ) u_mux (
    .in_1     (in_1),
    .in_2     (in_2),
    .in_3     (in_3),
    .in_4     (in_4),
    .sel      (sel),
    .out_data (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_rng_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rng_mux_arbiter
// Description : Scoreboard bench for rng_mux_arbiter. The driver applies
//               inputs each cycle and a transaction-level model pushes the
//               expected per-cycle outputs and expected transferred beats;
//               a monitor pops and compares them independently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] in_arr [4];
  logic [3:0] burst_len = 4'd0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_data;
  logic [3:0] gnt;
  logic [1:0] sel;

  always #5 clk = ~clk;

  rng_mux_arbiter #(.WIDTH_4(4), .WIDTH_2(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_1      (in_arr[0]),
    .in_2      (in_arr[1]),
    .in_3      (in_arr[2]),
    .in_4      (in_arr[3]),
    .burst_len (burst_len),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gnt       (gnt),
    .sel       (sel)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic [3:0] data;
  } exp_t;

  exp_t       eq[$];
  logic [3:0] xq[$];
  int         checks = 0;
  int         errors = 0;

  // Transaction-level model: a grant is "serving source m_src with m_left
  // beats still owed"; any non-serving cycle (idle or the post-grant gap)
  // arbitrates for the next cycle.
  bit m_serving = 0;
  int m_src     = 0;
  int m_last    = 3;
  int m_left    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] bl,
                       input logic rdy, input logic rn);
    exp_t e;
    @(negedge clk);
    req       = r;
    burst_len = bl;
    out_ready = rdy;
    rst_n     = rn;
    for (int i = 0; i < 4; i++) in_arr[i] = 4'($urandom_range(0, 15));
    #1;
    if (!rn) begin
      m_serving = 0;
      m_src     = 0;
      m_last    = 3;
      m_left    = 0;
      e.gnt = 4'd0; e.sel = 2'd0; e.vld = 1'b0; e.data = in_arr[0];
      eq.push_back(e);
    end else begin
      e.gnt  = m_serving ? 4'(1 << m_src) : 4'd0;
      e.sel  = 2'(m_src);
      e.vld  = m_serving && r[m_src];
      e.data = in_arr[m_src];
      eq.push_back(e);
      if (m_serving) begin
        if (!r[m_src]) begin
          m_serving = 0;
        end else if (rdy) begin
          xq.push_back(in_arr[m_src]);
          m_left--;
          if (m_left == 0) m_serving = 0;
        end
      end else if (r != 4'd0) begin
        for (int k = 1; k <= 4; k++) begin
          int idx;
          idx = (m_last + k) % 4;
          if (r[idx]) begin
            m_src = idx;
            break;
          end
        end
        m_last    = m_src;
        m_left    = int'(bl) + 1;
        m_serving = 1;
      end
    end
  endtask

  // Monitor: checks every cycle's control outputs and every accepted beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (eq.size() == 0) begin
        chk("exp_queue_empty", 32'd1, 32'd0);
      end else begin
        e = eq.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("sel", 32'(sel), 32'(e.sel));
        chk("out_valid", 32'(out_valid), 32'(e.vld));
        chk("out_data", 32'(out_data), 32'(e.data));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (xq.size() == 0) chk("unexpected_beat", 32'(out_data), 32'hFFFF);
        else chk("beat_data", 32'(out_data), 32'(xq.pop_front()));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) in_arr[i] = 4'd0;

    // Reset, then all sources requesting single-beat bursts.
    repeat (3) cycle(4'b0000, 4'd0, 1'b1, 1'b0);
    repeat (12) cycle(4'b1111, 4'd0, 1'b1, 1'b1);

    // Single source with four-beat bursts, re-granted after each gap.
    repeat (2) cycle(4'b0000, 4'd0, 1'b1, 1'b0);
    repeat (12) cycle(4'b0100, 4'd3, 1'b1, 1'b1);

    // Source 1, eight beats with toggling ready; burst_len changes mid-burst.
    repeat (3) cycle(4'b0000, 4'd0, 1'b1, 1'b1);
    cycle(4'b0010, 4'd7, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(4'b0010, 4'(i), 1'(i % 2 == 0), 1'b1);
    repeat (2) cycle(4'b0000, 4'd0, 1'b1, 1'b1);

    // Source 0 long burst released early, then 1001 must go to source 3.
    repeat (2) cycle(4'b0000, 4'd0, 1'b1, 1'b0);
    cycle(4'b0001, 4'd15, 1'b1, 1'b1);
    repeat (2) cycle(4'b0001, 4'd15, 1'b1, 1'b1);
    cycle(4'b0000, 4'd15, 1'b1, 1'b1);
    repeat (4) cycle(4'b1001, 4'd0, 1'b1, 1'b1);

    // Reset on the third beat, then 1010 must grant source 1 first.
    repeat (2) cycle(4'b0000, 4'd0, 1'b1, 1'b1);
    repeat (3) cycle(4'b0001, 4'd7, 1'b1, 1'b1);
    repeat (2) cycle(4'b0001, 4'd7, 1'b1, 1'b0);
    repeat (6) cycle(4'b1010, 4'd0, 1'b1, 1'b1);

    // Randomized traffic with occasional resets.
    begin
      logic [3:0] r;
      r = 4'd0;
      for (int n = 0; n < 2000; n++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        cycle(r,
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2)),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 99) != 0));
      end
    end

    #5;
    chk("leftover_cycle_exp", 32'(eq.size()), 32'd0);
    chk("leftover_beats", 32'(xq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
